// File: rtl/wbc_ram_pkg.sv
// rtl/wbc_ram_pkg.sv - shared types and constants for the two-master RAM arbiter
package wbc_ram_pkg;

    localparam int AW_DEFAULT = 13;

    localparam int M0 = 0;
    localparam int M1 = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/wbc_ram_arb_if.sv
// rtl/wbc_ram_arb_if.sv - Wishbone classic master port seen from the RAM arbiter
interface wbc_ram_arb_if #(
    parameter int AW = wbc_ram_pkg::AW_DEFAULT
);
    logic          cyc_i;
    logic          stb_i;
    logic          we_i;
    logic [1:0]    sel_i;
    logic [AW-1:0] adr_i;
    logic [15:0]   dat_i;
    logic [15:0]   dat_o;
    logic          ack_o;

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/ram_16k.sv
// rtl/ram_16k.sv - 16-bit LUT RAM with registered address and byte enables
module ram_16k #(
    parameter int AW = wbc_ram_pkg::AW_DEFAULT
) (
    input  logic          clock,
    input  logic [AW-1:0] addra,
    input  logic [15:0]   dina,
    input  logic          wea,
    input  logic [1:0]    byteena,
    output logic [15:0]   douta
);

    logic [15:0]   r_mem [0:(2**AW)-1];
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [1:0]    r_be;

    // Address and write controls are captured one cycle before data is written
    always_ff @(posedge clock) begin
        r_addr <= addra;
        r_we   <= wea;
        r_be   <= byteena;
        if (r_we) begin
            if (r_be[0]) r_mem[r_addr][7:0]  <= dina[7:0];
            if (r_be[1]) r_mem[r_addr][15:8] <= dina[15:8];
        end
    end

    assign douta = r_mem[r_addr];

endmodule

// File: rtl/wbc_rr_arb2.sv
// rtl/wbc_rr_arb2.sv - two-requester round-robin or fixed-priority arbiter
module wbc_rr_arb2 #(
    parameter bit RR = 1'b1
) (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    // One-hot grant; on a tie round-robin favours the master that did not win last
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11: begin
                if (RR) begin
                    o_grant = i_last ? 2'b01 : 2'b10;
                end else begin
                    o_grant = 2'b01;
                end
            end
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/wbc_ram_arb.sv
// rtl/wbc_ram_arb.sv - two-master Wishbone arbiter and access sequencer for the LUT RAM
module wbc_ram_arb
    import wbc_ram_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter bit RR = 1'b1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n,
    wbc_ram_arb_if.slave  m0,
    wbc_ram_arb_if.slave  m1,
    output logic [AW-1:0] ram_addr_o,
    output logic [15:0]   ram_din_o,
    output logic          ram_we_o,
    output logic [1:0]    ram_be_o,
    input  logic [15:0]   ram_dout_i,
    output logic [1:0]    grant_o
);

    state_t      r_state;
    logic        r_owner;
    logic        r_last;
    logic [1:0]  r_ack;
    logic [15:0] r_dat0;
    logic [15:0] r_dat1;

    logic [1:0]  w_req;
    logic [1:0]  w_grant;
    logic        w_grant_now;
    logic        w_win;
    logic        w_sel_idx;
    logic        w_owner_req;

    assign w_req = {m1.cyc_i & m1.stb_i, m0.cyc_i & m0.stb_i};

    wbc_rr_arb2 #(
        .RR (RR)
    ) u_arb (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    // A grant only happens from IDLE; ACCESS/ACK never look at new requests
    assign w_grant_now = (r_state == ST_IDLE) && (w_req != 2'b00);
    assign w_win       = w_grant[1];
    assign w_sel_idx   = w_grant_now ? w_win : r_owner;
    assign w_owner_req = r_owner ? w_req[1] : w_req[0];

    // RAM port mux: winner during the grant cycle, registered owner afterwards
    always_comb begin
        ram_addr_o = m0.adr_i;
        if (w_grant_now || (r_state != ST_IDLE)) begin
            ram_addr_o = w_sel_idx ? m1.adr_i : m0.adr_i;
        end
        ram_be_o  = w_sel_idx ? m1.sel_i : m0.sel_i;
        ram_din_o = r_owner ? m1.dat_i : m0.dat_i;
        ram_we_o  = w_grant_now && (w_win ? m1.we_i : m0.we_i);
        grant_o   = 2'b00;
        if (w_grant_now) begin
            grant_o = w_grant;
        end else if (r_state != ST_IDLE) begin
            grant_o = idx_to_onehot(r_owner);
        end
    end

    // Access sequencer: grant, one RAM cycle, one ack cycle, then back to idle
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= 1'(M0);
            r_last  <= 1'(M1);
            r_ack   <= 2'b00;
            r_dat0  <= 16'h0000;
            r_dat1  <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_now) begin
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (w_owner_req) begin
                        if (r_owner) begin
                            r_ack[1] <= 1'b1;
                            r_dat1   <= ram_dout_i;
                        end else begin
                            r_ack[0] <= 1'b1;
                            r_dat0   <= ram_dout_i;
                        end
                    end
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_ack   <= 2'b00;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ack   <= 2'b00;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0.ack_o = r_ack[0];
    assign m1.ack_o = r_ack[1];
    assign m0.dat_o = r_dat0;
    assign m1.dat_o = r_dat1;

endmodule

// File: tb/tb_wbc_ram_arb.sv
// tb/tb_wbc_ram_arb.sv - self-checking bench for wbc_ram_arb (round-robin and fixed-priority copies)
`timescale 1ns/1ps
module tb_wbc_ram_arb;

    localparam int AW    = 13;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Master stimulus, shared by both DUT copies
    logic          m_cyc [2];
    logic          m_stb [2];
    logic          m_we  [2];
    logic [1:0]    m_sel [2];
    logic [AW-1:0] m_adr [2];
    logic [15:0]   m_dat [2];

    // Observed outputs per DUT copy (0 = round-robin, 1 = fixed priority)
    logic [1:0]    o_ack   [2];
    logic [15:0]   o_dat0  [2];
    logic [15:0]   o_dat1  [2];
    logic [AW-1:0] o_addr  [2];
    logic [15:0]   o_din   [2];
    logic          o_we    [2];
    logic [1:0]    o_be    [2];
    logic [1:0]    o_grant [2];

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        wbc_ram_arb_if #(.AW(AW)) if_m0 ();
        wbc_ram_arb_if #(.AW(AW)) if_m1 ();
        logic [AW-1:0] w_addr;
        logic [15:0]   w_din;
        logic [15:0]   w_dout;
        logic          w_we;
        logic [1:0]    w_be;
        logic [1:0]    w_grant;

        assign if_m0.cyc_i = m_cyc[0];
        assign if_m0.stb_i = m_stb[0];
        assign if_m0.we_i  = m_we[0];
        assign if_m0.sel_i = m_sel[0];
        assign if_m0.adr_i = m_adr[0];
        assign if_m0.dat_i = m_dat[0];
        assign if_m1.cyc_i = m_cyc[1];
        assign if_m1.stb_i = m_stb[1];
        assign if_m1.we_i  = m_we[1];
        assign if_m1.sel_i = m_sel[1];
        assign if_m1.adr_i = m_adr[1];
        assign if_m1.dat_i = m_dat[1];

        wbc_ram_arb #(
            .AW (AW),
            .RR ((g == 0) ? 1'b1 : 1'b0)
        ) u_dut (
            .wb_clk_i   (clk),
            .wb_rst_n   (rst_n),
            .m0         (if_m0),
            .m1         (if_m1),
            .ram_addr_o (w_addr),
            .ram_din_o  (w_din),
            .ram_we_o   (w_we),
            .ram_be_o   (w_be),
            .ram_dout_i (w_dout),
            .grant_o    (w_grant)
        );

        ram_16k #(.AW(AW)) u_ram (
            .clock   (clk),
            .addra   (w_addr),
            .dina    (w_din),
            .wea     (w_we),
            .byteena (w_be),
            .douta   (w_dout)
        );

        assign o_ack[g]   = {if_m1.ack_o, if_m0.ack_o};
        assign o_dat0[g]  = if_m0.dat_o;
        assign o_dat1[g]  = if_m1.dat_o;
        assign o_addr[g]  = w_addr;
        assign o_din[g]   = w_din;
        assign o_we[g]    = w_we;
        assign o_be[g]    = w_be;
        assign o_grant[g] = w_grant;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Behavioural model: each access is a grant, then one RAM cycle, then one ack cycle
    int            md_busy   [2];
    logic          md_owner  [2];
    logic          md_last   [2];
    logic [1:0]    md_ack    [2];
    logic [15:0]   md_dat    [2][2];
    logic          md_dat_ok [2][2];
    logic          md_twe    [2];
    logic [AW-1:0] md_tadr   [2];
    logic [1:0]    md_tbe    [2];
    logic [15:0]   mem       [2][DEPTH];
    logic [1:0]    known     [2][DEPTH];

    int          win;
    int          own;
    logic        rr;
    logic [1:0]  req;
    logic [15:0] old;
    logic        old_ok;

    initial begin
        for (int d = 0; d < 2; d++) begin
            md_busy[d] = 0; md_owner[d] = 1'b0; md_last[d] = 1'b1; md_ack[d] = 2'b00;
            md_twe[d] = 1'b0; md_tadr[d] = '0; md_tbe[d] = 2'b00;
            for (int m = 0; m < 2; m++) begin
                md_dat[d][m] = 16'h0; md_dat_ok[d][m] = 1'b1;
            end
            for (int a = 0; a < DEPTH; a++) begin
                mem[d][a] = 16'h0; known[d][a] = 2'b00;
            end
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                rr  = (d == 0);
                req = {m_cyc[1] & m_stb[1], m_cyc[0] & m_stb[0]};
                if (req == 2'b01)      win = 0;
                else if (req == 2'b10) win = 1;
                else if (req == 2'b11) win = (rr && !md_last[d]) ? 1 : 0;
                else                   win = -1;
                own = md_owner[d] ? 1 : 0;

                chk("m0_ack", d, 32'(o_ack[d][0]), 32'(md_ack[d][0]));
                chk("m1_ack", d, 32'(o_ack[d][1]), 32'(md_ack[d][1]));
                if (md_dat_ok[d][0]) chk("m0_dat", d, 32'(o_dat0[d]), 32'(md_dat[d][0]));
                if (md_dat_ok[d][1]) chk("m1_dat", d, 32'(o_dat1[d]), 32'(md_dat[d][1]));

                if (md_busy[d] == 0) begin
                    if (win < 0) begin
                        chk("idle_grant", d, 32'(o_grant[d]), 32'd0);
                        chk("idle_we", d, 32'(o_we[d]), 32'd0);
                        chk("idle_addr", d, 32'(o_addr[d]), 32'(m_adr[0]));
                    end else begin
                        chk("gnt_grant", d, 32'(o_grant[d]), 32'(1 << win));
                        chk("gnt_we", d, 32'(o_we[d]), 32'(m_we[win]));
                        chk("gnt_addr", d, 32'(o_addr[d]), 32'(m_adr[win]));
                        chk("gnt_be", d, 32'(o_be[d]), 32'(m_sel[win]));
                    end
                end else begin
                    chk("own_grant", d, 32'(o_grant[d]), 32'(1 << own));
                    chk("own_we", d, 32'(o_we[d]), 32'd0);
                    chk("own_addr", d, 32'(o_addr[d]), 32'(m_adr[own]));
                    chk("own_be", d, 32'(o_be[d]), 32'(m_sel[own]));
                    if (md_busy[d] == 1) chk("own_din", d, 32'(o_din[d]), 32'(m_dat[own]));
                end

                // Advance the model across the coming rising edge
                if (!rst_n) begin
                    if (md_busy[d] == 0 && win >= 0 && m_we[win]) known[d][m_adr[win]] = 2'b00;
                    if (md_busy[d] == 1 && md_twe[d]) known[d][md_tadr[d]] = 2'b00;
                    md_busy[d] = 0; md_owner[d] = 1'b0; md_last[d] = 1'b1; md_ack[d] = 2'b00;
                    for (int m = 0; m < 2; m++) begin
                        md_dat[d][m] = 16'h0; md_dat_ok[d][m] = 1'b1;
                    end
                end else if (md_busy[d] == 0) begin
                    if (win >= 0) begin
                        md_owner[d] = (win == 1);
                        md_last[d]  = (win == 1);
                        md_twe[d]   = m_we[win];
                        md_tadr[d]  = m_adr[win];
                        md_tbe[d]   = m_sel[win];
                        md_busy[d]  = 1;
                    end
                end else if (md_busy[d] == 1) begin
                    old    = mem[d][md_tadr[d]];
                    old_ok = (known[d][md_tadr[d]] == 2'b11);
                    if (md_twe[d]) begin
                        if (md_tbe[d][0]) mem[d][md_tadr[d]][7:0]  = m_dat[own][7:0];
                        if (md_tbe[d][1]) mem[d][md_tadr[d]][15:8] = m_dat[own][15:8];
                        known[d][md_tadr[d]] = known[d][md_tadr[d]] | md_tbe[d];
                    end
                    if (req[own]) begin
                        md_ack[d][own]    = 1'b1;
                        md_dat[d][own]    = old;
                        md_dat_ok[d][own] = old_ok;
                    end
                    md_busy[d] = 2;
                end else begin
                    md_ack[d]  = 2'b00;
                    md_busy[d] = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic on, input logic we, input logic [AW-1:0] adr,
                         input logic [1:0] sel, input logic [15:0] dat);
        m_cyc[m] = on; m_stb[m] = on; m_we[m] = we;
        m_sel[m] = sel; m_adr[m] = adr; m_dat[m] = dat;
    endtask

    // One complete access timed on the round-robin copy; reports latency, read data, cycle-T address
    task automatic xfer(input int m, input logic we, input logic [AW-1:0] adr, input logic [1:0] sel,
                        input logic [15:0] dat, output int lat, output logic [15:0] rdata,
                        output logic [AW-1:0] addr_t);
        tick();
        set_m(m, 1'b1, we, adr, sel, dat);
        lat = -1;
        rdata = 16'h0;
        @(negedge clk);
        addr_t = o_addr[0];
        for (int k = 0; k < 12; k++) begin
            if (o_ack[0][m]) begin
                lat = k;
                rdata = (m == 1) ? o_dat1[0] : o_dat0[0];
                break;
            end
            @(negedge clk);
        end
        tick();
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    int            lat;
    logic [15:0]   rd;
    logic [AW-1:0] at;
    int            we_n, ack_n, both_n, alt_bad, gap_bad, n_rr, fp0, fp1, prev_who, prev_c, who, first_k;

    initial begin
        for (int m = 0; m < 2; m++) set_m(m, 1'b0, 1'b0, '0, 2'b00, 16'h0);
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Preload through master 1
        xfer(1, 1'b1, 13'h0010, 2'b11, 16'h1234, lat, rd, at);
        xfer(1, 1'b1, 13'h1FFF, 2'b11, 16'h5555, lat, rd, at);

        // Single read with T+2 latency
        xfer(0, 1'b0, 13'h0010, 2'b11, 16'h0, lat, rd, at);
        chk("t1_addr_T", 0, 32'(at), 32'h0010);
        chk("t1_latency", 0, 32'(lat), 32'd2);
        chk("t1_data", 0, 32'(rd), 32'h1234);

        // Byte writes at the top address
        xfer(1, 1'b1, 13'h1FFF, 2'b01, 16'hABCD, lat, rd, at);
        xfer(1, 1'b0, 13'h1FFF, 2'b11, 16'h0, lat, rd, at);
        chk("t2_low_byte", 0, 32'(rd), 32'h55CD);
        xfer(1, 1'b1, 13'h1FFF, 2'b10, 16'h7700, lat, rd, at);
        xfer(1, 1'b0, 13'h1FFF, 2'b11, 16'h0, lat, rd, at);
        chk("t2_high_byte", 0, 32'(rd), 32'h77CD);
        xfer(1, 1'b1, 13'h1FFF, 2'b00, 16'hFFFF, lat, rd, at);
        chk("t2_sel00_acked", 0, 32'(lat), 32'd2);
        xfer(1, 1'b0, 13'h1FFF, 2'b11, 16'h0, lat, rd, at);
        chk("t2_sel00_nochange", 0, 32'(rd), 32'h77CD);

        // Abort: master drops the strobe during ACCESS
        tick();
        set_m(0, 1'b1, 1'b1, 13'h0100, 2'b11, 16'hBEEF);
        we_n = 0;
        ack_n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            we_n += int'(o_we[0]);
            ack_n += int'(o_ack[0][0]);
            tick();
            if (k == 0) begin
                m_cyc[0] = 1'b0;
                m_stb[0] = 1'b0;
            end
        end
        chk("t5_we_cycles", 0, 32'(we_n), 32'd1);
        chk("t5_no_ack", 0, 32'(ack_n), 32'd0);
        xfer(0, 1'b0, 13'h0100, 2'b11, 16'h0, lat, rd, at);
        chk("t5_readback", 0, 32'(rd), 32'hBEEF);

        // Contention: both masters hold continuous reads
        tick();
        set_m(0, 1'b1, 1'b0, 13'h0010, 2'b11, 16'h0);
        set_m(1, 1'b1, 1'b0, 13'h1FFF, 2'b11, 16'h0);
        both_n = 0; alt_bad = 0; gap_bad = 0; n_rr = 0; fp0 = 0; fp1 = 0; prev_who = -1; prev_c = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (o_ack[0] == 2'b11 || o_ack[1] == 2'b11) both_n++;
            if (o_ack[0] != 2'b00) begin
                who = o_ack[0][1] ? 1 : 0;
                if (prev_who >= 0) begin
                    if (who == prev_who) alt_bad++;
                    if (c - prev_c != 3) gap_bad++;
                end
                prev_who = who;
                prev_c = c;
                n_rr++;
            end
            fp0 += int'(o_ack[1][0]);
            fp1 += int'(o_ack[1][1]);
            if (c < 29) tick();
        end
        chk("t3_both_acks", 0, 32'(both_n), 32'd0);
        chk("t3_alternate", 0, 32'(alt_bad), 32'd0);
        chk("t3_spacing", 0, 32'(gap_bad), 32'd0);
        chk("t3_ack_count", 0, 32'(n_rr), 32'd10);
        chk("t4_m0_count", 1, 32'(fp0), 32'd10);
        chk("t4_m1_starved", 1, 32'(fp1), 32'd0);
        tick();
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        first_k = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (first_k < 0 && o_ack[1][1]) first_k = k;
            tick();
        end
        chk("t4_m1_after_drop", 1, 32'(first_k), 32'd2);
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        repeat (3) tick();

        // Reset during the ACK cycle of an m1 read
        set_m(1, 1'b1, 1'b0, 13'h1FFF, 2'b11, 16'h0);
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        rst_n = 1'b0;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        @(negedge clk);
        chk("t6_ack_in_ack", 0, 32'(o_ack[0][1]), 32'd1);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ack_cleared", 0, 32'(o_ack[0][1]), 32'd0);
        chk("t6_grant_idle", 0, 32'(o_grant[0]), 32'd0);
        chk("t6_dat_reset", 0, 32'(o_dat1[0]), 32'd0);
        xfer(0, 1'b0, 13'h0010, 2'b11, 16'h0, lat, rd, at);
        chk("t6_latency", 0, 32'(lat), 32'd2);
        chk("t6_data", 0, 32'(rd), 32'h1234);

        // Randomized traffic, checked cycle by cycle by the model
        for (int c = 0; c < 800; c++) begin
            tick();
            rst_n = ($urandom_range(0, 99) != 0);
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       at = 13'h0010;
                        1:       at = 13'h1FFF;
                        2:       at = 13'h0100;
                        default: at = 13'($urandom_range(0, 15));
                    endcase
                    set_m(m, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), at,
                          2'($urandom_range(0, 3)), 16'($urandom));
                    if ($urandom_range(0, 5) == 0) m_cyc[m] = 1'b1;
                end
            end
        end
        tick();
        rst_n = 1'b1;
        for (int m = 0; m < 2; m++) set_m(m, 1'b0, 1'b0, '0, 2'b00, 16'h0);
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wbc_ram_arb.md
Name: wbc_ram_arb

Overview:
- Two-master Wishbone classic arbiter and access sequencer for the 8K-word on-chip LUT RAM (`ram_16k`).
- Master 0 is the CPU bus; master 1 is the loader/DMA port.
- Grants one access at a time, drives the RAM address, write-enable, byte-enable and data ports with the RAM's registered-address timing, and returns a registered `ack` plus read data.

Parameters:
- AW, 13, word-address width; RAM depth is 2**AW.
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (m0 always wins).

Ports:
- wb_clk_i  in  1  system clock; all logic on the rising edge.
- wb_rst_n  in  1  reset, synchronous, active-low.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone cycle, strobe, write.
- m0_sel_i  in  2  master 0 byte selects ([0] = low byte).
- m0_adr_i  in  AW  master 0 word address.
- m0_dat_i  in  16  master 0 write data.
- m0_dat_o  out  16  master 0 read data.
- m0_ack_o  out  1  master 0 acknowledge.
- m1_*  same set and widths as m0_*, for master 1.
- ram_addr_o  out  AW  to RAM `addra`.
- ram_din_o  out  16  to RAM `dina`.
- ram_we_o  out  1  to RAM `wea`.
- ram_be_o  out  2  to RAM `byteena`.
- ram_dout_i  in  16  from RAM `douta` (combinational from the RAM's registered address).
- grant_o  out  2  one-hot current owner, 00 when idle; debug/visibility.

Behaviour:
- **Request:** `mN_req = mN_cyc_i & mN_stb_i`.
- **Reset (wb_rst_n=0 at an edge):**
  - state = IDLE.
  - m0_ack_o = m1_ack_o = 0; m0_dat_o = m1_dat_o = 0.
  - owner = 0; last = 1, so m0 wins the first tie.
  - ram_we_o = 0; grant_o = 00.
- **FSM states:** IDLE, ACCESS, ACK.
- **IDLE:**
  - No request: outputs quiescent; ram_we_o = 0; ram_addr_o follows m0_adr_i.
  - Any request: grant combinationally in the same cycle.
    - ram_addr_o = owner address; ram_be_o = owner sel; ram_we_o = owner we.
    - owner register loaded; go to ACCESS.
- **Arbitration:**
  - One request: that master wins.
  - Both requesting, RR=1: the master not equal to `last` wins.
  - Both requesting, RR=0: m0 wins.
  - `last` updates at the grant edge.
- **ACCESS:**
  - ram_we_o = 0; ram_addr_o, ram_be_o held from owner.
  - ram_din_o = owner dat_i.
  - The RAM's byte write commits at the end of this cycle; ram_dout_i is valid now.
  - Ack decision at the edge:
    - If the owner's req is still high, register mN_ack_o = 1 and mN_dat_o = ram_dout_i, and go to ACK.
    - Otherwise (aborted by the master) go to ACK with ack = 0; the RAM write still commits.
- **ACK:**
  - The ack is a single-cycle pulse; it is cleared at the edge leaving ACK.
  - Next state is IDLE, unconditionally; there is no back-to-back grant from ACK.
  - Throughput: one access per 3 cycles.
  - Read data is held on mN_dat_o until that master's next ack.
- **Latency:** req sampled in cycle T → ack high in cycle T+2, for both read and write.
- **Data mux:** ram_din_o is always muxed by the owner register, never by the live requests. ram_we_o is asserted only in the IDLE grant cycle, so the RAM never fires a write twice.
- **Byte enables:** sel=00 on a write results in no memory change but is still acked. Reads ignore sel and return the full word.
- **Address space:** all AW bits are decoded; there is no out-of-range case.
- **Reset mid-access:**
  - The FSM returns to IDLE and no ack is issued.
  - A write granted in the cycle before reset may still commit to the RAM, since the RAM has no reset. The content of that word is unspecified.
- **Simultaneous events:**
  - A request arriving during ACCESS/ACK waits; the master holds stb.
  - The non-owner's ack is never asserted.

Decomposition:
- Shared package/include `wbc_ram_pkg`:
  - State encodings: IDLE=2'd0, ACCESS=2'd1, ACK=2'd2.
  - Master index constants: M0=0, M1=1.
  - Default AW.
- One natural sub-module: `wbc_rr_arb2`, a two-requester round-robin/fixed arbiter.
  - Inputs: req[1:0], last, RR.
  - Output: one-hot grant.
- The top-level FSM and RAM port mux stay in `wbc_ram_arb`. Benches instantiate `ram_16k` behind it.

Test Plan:
1. **Single read:** after reset, m0 read adr=0x0010 (memory preloaded 0x1234) → ram_addr_o=0x0010 in cycle T; m0_ack_o high only in T+2 with m0_dat_o=0x1234.
2. **Byte writes:** m1 write adr=0x1FFF, sel=01, dat=0xABCD to a word holding 0x5555 → readback 0x55CD; then sel=10, dat=0x7700 → readback 0x77CD.
3. **Contention, RR=1:** both masters hold continuous reads → grants alternate m0,m1,m0,m1; each ack spaced 3 cycles; no cycle has both acks high.
4. **Contention, RR=0:** both masters hold continuous requests → m0 served every 3 cycles and m1 never served; m1 is served on the first IDLE after m0 drops cyc.
5. **Abort:** m0 write adr=0x0100, dat=0xBEEF; drops stb in ACCESS → no m0_ack_o; readback 0xBEEF; ram_we_o high for exactly one cycle.
6. **Reset mid-access:** wb_rst_n low during ACK of an m1 read → m1_ack_o=0, grant_o=00 next cycle; next m0 read completes normally with T+2 latency.
